// File: rtl/div_pkg.sv
// Shared FSM encoding and cycle-count helpers for the divider issue/collect stage.
package div_pkg;

  localparam logic [2:0] S_DRAIN   = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_DZ      = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;
  localparam logic [2:0] S_HOLD    = 3'd7;

  // Long enough for any division started before a reset or timeout to finish.
  function automatic int drain_len(input int width);
    return width + 3;
  endfunction

  function automatic int timeout_len(input int width, input int slack);
    return width + 1 + slack;
  endfunction

endpackage

// File: rtl/div_op_fifo.sv
// Request FIFO holding {tag, divisor, dividend}; the caller guarantees no push when full
// and no pop when empty.
module div_op_fifo #(
  parameter int DW    = 20,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issues buffered divide requests one at a time to a non-pipelined divider core and
// presents each result on a registered valid/ready port.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int SLACK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dz,
  output logic             out_err,
  output logic             core_start,
  output logic [WIDTH-1:0] core_dividend,
  output logic [WIDTH-1:0] core_divider,
  input  logic [WIDTH-1:0] core_quotient,
  input  logic [WIDTH-1:0] core_remainder,
  input  logic             core_ready,
  output logic             busy
);

  localparam int DW          = TAG_W + 2 * WIDTH;
  localparam int CW          = $clog2(DEPTH) + 1;
  localparam int DRAIN_CYC   = drain_len(WIDTH);
  localparam int TIMEOUT_CYC = timeout_len(WIDTH, SLACK);
  localparam int CNT_MAX     = (DRAIN_CYC > TIMEOUT_CYC) ? DRAIN_CYC : TIMEOUT_CYC;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [2:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] op_dividend;
  logic [WIDTH-1:0] op_divisor;
  logic [TAG_W-1:0] op_tag;

  logic [CW-1:0]    fifo_count;
  logic [DW-1:0]    head_data;
  logic [WIDTH-1:0] head_dividend;
  logic [WIDTH-1:0] head_divisor;
  logic [TAG_W-1:0] head_tag;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign fifo_empty = (fifo_count == '0);
  assign in_ready   = (fifo_count != CW'(DEPTH)) && (state_reg != S_DRAIN);
  assign push       = in_valid && in_ready;
  assign pop        = (state_reg == S_IDLE) && !fifo_empty;
  assign {head_tag, head_divisor, head_dividend} = head_data;

  div_op_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({in_tag, in_divisor, in_dividend}),
    .pop       (pop),
    .pop_data  (head_data),
    .count     (fifo_count)
  );

  assign core_start    = (state_reg == S_ISSUE);
  assign core_dividend = op_dividend;
  assign core_divider  = op_divisor;
  assign busy          = (state_reg != S_IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_DRAIN;
      cnt_reg       <= '0;
      op_dividend   <= '0;
      op_divisor    <= '0;
      op_tag        <= '0;
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_tag       <= '0;
      out_dz        <= 1'b0;
      out_err       <= 1'b0;
    end else begin
      case (state_reg)
        S_DRAIN: begin
          if (cnt_reg == DRAIN_LAST) begin
            cnt_reg   <= '0;
            state_reg <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_IDLE: begin
          if (!fifo_empty) begin
            op_dividend <= head_dividend;
            op_divisor  <= head_divisor;
            op_tag      <= head_tag;
            state_reg   <= (head_divisor == '0) ? S_DZ : S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_reg   <= '0;
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (core_ready) begin
            state_reg <= S_CAPTURE;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            state_reg <= S_ERR;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_CAPTURE: begin
          out_quotient  <= core_quotient;
          out_remainder <= core_remainder;
          out_tag       <= op_tag;
          out_dz        <= 1'b0;
          out_err       <= 1'b0;
          out_valid     <= 1'b1;
          state_reg     <= S_HOLD;
        end
        S_DZ: begin
          out_quotient  <= '1;
          out_remainder <= op_dividend;
          out_tag       <= op_tag;
          out_dz        <= 1'b1;
          out_err       <= 1'b0;
          out_valid     <= 1'b1;
          state_reg     <= S_HOLD;
        end
        S_ERR: begin
          out_quotient  <= '0;
          out_remainder <= '0;
          out_tag       <= op_tag;
          out_dz        <= 1'b0;
          out_err       <= 1'b1;
          out_valid     <= 1'b1;
          state_reg     <= S_HOLD;
        end
        S_HOLD: begin
          // After a timeout the core may still be mid-division, so wait it out.
          if (out_ready) begin
            out_valid <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= out_err ? S_DRAIN : S_IDLE;
          end
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= S_DRAIN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed and randomized checks of div_issue_ctrl against a queue-based result model
// and a behavioural divider core stub.
module tb_div_issue_ctrl;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int SLACK   = 4;
  localparam int TIMEOUT = WIDTH + 1 + SLACK;
  localparam int DRAIN   = WIDTH + 3;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;
  logic [TAG_W-1:0] out_tag;
  logic             out_dz;
  logic             out_err;
  logic             core_start;
  logic [WIDTH-1:0] core_dividend;
  logic [WIDTH-1:0] core_divider;
  logic [WIDTH-1:0] core_quotient;
  logic [WIDTH-1:0] core_remainder;
  logic             core_ready;
  logic             busy;

  div_issue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W), .SLACK(SLACK)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_dividend    (in_dividend),
    .in_divisor     (in_divisor),
    .in_tag         (in_tag),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_quotient   (out_quotient),
    .out_remainder  (out_remainder),
    .out_tag        (out_tag),
    .out_dz         (out_dz),
    .out_err        (out_err),
    .core_start     (core_start),
    .core_dividend  (core_dividend),
    .core_divider   (core_divider),
    .core_quotient  (core_quotient),
    .core_remainder (core_remainder),
    .core_ready     (core_ready),
    .busy           (busy)
  );

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [TAG_W-1:0] tag;
    logic             dz;
  } res_t;

  res_t exp_q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   starts = 0;
  logic hang   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core stub: latches operands on start, answers WIDTH edges later with a 1-cycle ready.
  int               core_left = 0;
  logic [WIDTH-1:0] core_a = '0;
  logic [WIDTH-1:0] core_b = '1;
  initial begin
    core_ready     = 1'b0;
    core_quotient  = '0;
    core_remainder = '0;
  end
  always @(posedge clk) begin
    core_ready <= 1'b0;
    if (core_start) begin
      core_a    = core_dividend;
      core_b    = core_divider;
      core_left = WIDTH;
      starts    = starts + 1;
    end else if (core_left > 0) begin
      core_left = core_left - 1;
      if (core_left == 0 && !hang && core_b != '0) begin
        core_ready     <= 1'b1;
        core_quotient  <= core_a / core_b;
        core_remainder <= core_a % core_b;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [TAG_W-1:0] t);
    res_t e;
    e.tag = t;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [31:0] bundle_dut();
    return 32'({out_err, out_dz, out_tag, out_remainder, out_quotient});
  endfunction

  function automatic logic [31:0] bundle_exp(input res_t e, input logic err);
    return 32'({err, e.dz, e.tag, e.r, e.q});
  endfunction

  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [TAG_W-1:0] t);
    int n = 0;
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    in_tag      = t;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    chk("push_accept", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    exp_q.push_back(model(a, b, t));
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    chk("valid_wait", 32'(out_valid), 32'd1);
  endtask

  task automatic check_head(input string name);
    res_t e;
    if (exp_q.size() == 0) begin
      chk({name, "_unexpected"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(name, bundle_dut(), bundle_exp(e, 1'b0));
    end
  endtask

  task automatic drain_random(input int bound);
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < bound) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) check_head("rand_result");
      step();
      cyc++;
    end
    out_ready = 1'b0;
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [WIDTH-1:0] rand_divisor();
    if ($urandom_range(0, 4) == 0) return '0;
    return WIDTH'($urandom_range(1, (1 << WIDTH) - 1));
  endfunction

  initial begin
    int   n;
    int   s0;
    int   seen;
    res_t e;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    in_tag      = '0;
    out_ready   = 1'b0;
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_outputs", bundle_dut(), 32'd0);
    chk("rst_core_ops", 32'({core_dividend, core_divider}), 32'd0);

    rst_n = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("drain_after_reset", 32'(n), 32'(DRAIN));

    // Basic divide: result visible WIDTH+4 edges after the input handshake.
    push(8'd100, 8'd7, 4'd3);
    wait_valid(n);
    chk("lat_normal", 32'(n), 32'(WIDTH + 4));
    check_head("basic_result");
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("valid_cleared", 32'(out_valid), 32'd0);

    // Divide by zero is resolved locally in two edges without a core start.
    s0 = starts;
    push(8'd55, 8'd0, 4'd9);
    wait_valid(n);
    chk("lat_dz", 32'(n), 32'd2);
    check_head("dz_result");
    chk("dz_no_core_start", 32'(starts), 32'(s0));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Backpressure: one request in flight plus DEPTH queued fills the block.
    for (int i = 0; i < 5; i++)
      push(8'($urandom_range(0, 255)), rand_divisor(), 4'(i));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    wait_valid(n);
    for (int k = 0; k < 20; k++) begin
      chk("hold_stable", bundle_dut(), bundle_exp(exp_q[0], 1'b0));
      chk("hold_valid", 32'(out_valid), 32'd1);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (exp_q.size() == 0) break;
      e = exp_q[0];
      wait_valid(n);
      if (i > 0) chk("gap", 32'(n), e.dz ? 32'd2 : 32'(WIDTH + 4));
      check_head("bp_result");
      step();
    end
    out_ready = 1'b0;

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++)
        push(8'($urandom_range(0, 255)), rand_divisor(), 4'($urandom_range(0, 15)));
      drain_random(3000);
    end

    // Timeout: the core never answers.
    hang = 1'b1;
    push(8'd200, 8'd9, 4'd5);
    n = 0;
    while (!core_start && n < 50) begin
      step();
      n++;
    end
    chk("to_core_start", 32'(core_start), 32'd1);
    step();
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    // ERR is entered TIMEOUT edges after WAIT entry and loads the output one edge later.
    chk("lat_timeout", 32'(n), 32'(TIMEOUT + 1));
    e = exp_q.pop_front();
    chk("timeout_result", bundle_dut(), 32'({1'b1, 1'b0, e.tag, 8'h00, 8'h00}));
    hang = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("to_drain_busy", 32'(busy), 32'd1);
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("drain_after_err", 32'(n), 32'(DRAIN));
    push(8'd30, 8'd4, 4'd6);
    wait_valid(n);
    check_head("after_err_result");
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset while the core is busy.
    push(8'd77, 8'd5, 4'd7);
    n = 0;
    while (!core_start && n < 50) begin
      step();
      n++;
    end
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", bundle_dut(), 32'd0);
    chk("midrst_ctrl", 32'({out_valid, in_ready, core_start, busy}), 32'b0001);
    chk("midrst_core_ops", 32'({core_dividend, core_divider}), 32'd0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    n = 0;
    seen = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
      if (out_valid) seen++;
    end
    chk("drain_after_midrst", 32'(n), 32'(DRAIN));
    chk("midrst_no_result", 32'(seen), 32'd0);
    push(8'd9, 8'd3, 4'd8);
    wait_valid(n);
    check_head("after_rst_result");
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Push coinciding with a pop at count 1.
    push(8'd250, 8'd11, 4'd1);
    push(8'd17, 8'd0, 4'd2);
    wait_valid(n);
    out_ready = 1'b1;
    check_head("pp_first");
    step();
    push(8'd63, 8'd8, 4'd3);
    for (int i = 0; i < 2; i++) begin
      wait_valid(n);
      check_head("pp_result");
      step();
    end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) seen++;
      step();
    end
    out_ready = 1'b0;
    chk("pp_no_duplicate", 32'(seen), 32'd0);
    chk("final_idle", 32'(busy), 32'd0);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Issue/collect stage in front of the non-pipelined restoring divider core. It buffers operand requests in a small FIFO and issues them one at a time to the core with a one-cycle `core_start` pulse. It captures the core's quotient and remainder into a registered valid/ready output port. Divide-by-zero is resolved locally without using the core, and a watchdog reports results the core never delivers.

## Interface
- `WIDTH`, 8, operand/result width; also passed to the core.
- `DEPTH`, 4, request FIFO entries; power of 2, at least 2.
- `TAG_W`, 4, width of the request tag returned with each result.
- `SLACK`, 4, extra cycles beyond `WIDTH+1` allowed before timeout.

Ports. One clock; reset is asynchronous and active-low: `clk`, `rst_n`.
- `clk` in 1: clock.
- `rst_n` in 1: async active-low reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: FIFO can accept; reset 0.
- `in_dividend` in WIDTH: dividend.
- `in_divisor` in WIDTH: divisor.
- `in_tag` in TAG_W: request tag.
- `out_valid` out 1: result present; reset 0.
- `out_ready` in 1: consumer accepts.
- `out_quotient` out WIDTH: quotient; reset 0.
- `out_remainder` out WIDTH: remainder; reset 0.
- `out_tag` out TAG_W: tag of the result; reset 0.
- `out_dz` out 1: divisor was 0; reset 0.
- `out_err` out 1: core timeout; reset 0.
- `core_start` out 1: one-cycle issue pulse; reset 0.
- `core_dividend` out WIDTH: operand held to core; reset 0.
- `core_divider` out WIDTH: operand held to core; reset 0.
- `core_quotient` in WIDTH: core result.
- `core_remainder` in WIDTH: core result.
- `core_ready` in 1: core completion pulse.
- `busy` out 1: FSM not in IDLE, or FIFO not empty; reset 1, because reset enters DRAIN.

## Operation
- **FIFO.** Push when `in_valid && in_ready`. `in_ready = (count != DEPTH) && !drain_active`. Pop and push in the same cycle when full is illegal, because `in_ready` is 0 when full. Pop and push in the same cycle when 1 ≤ count < DEPTH leaves count unchanged. Pointers wrap modulo DEPTH.
- **FSM states and transitions:**
  - DRAIN: hold for `WIDTH+3` cycles, then go to IDLE.
  - IDLE: if the FIFO is not empty, pop the head into the op register. If divisor == 0, go to DZ; otherwise go to ISSUE.
  - ISSUE: `core_start` = 1 for exactly this cycle; go to WAIT.
  - WAIT: if `core_ready` is sampled 1, go to CAPTURE. If the timeout counter reaches `WIDTH+1+SLACK`, go to ERR.
  - CAPTURE: load `core_quotient`, `core_remainder`, the tag, `out_dz`=0 and `out_err`=0; set `out_valid`; go to HOLD.
  - DZ: load quotient = all ones, remainder = dividend, `out_dz`=1; set `out_valid`; go to HOLD.
  - ERR: load quotient = 0, remainder = 0, `out_err`=1; set `out_valid`; go to HOLD. The core state is unknown, so leave HOLD through DRAIN instead of IDLE.
  - HOLD: keep all `out_*` signals stable while `out_valid && !out_ready`. On handshake, clear `out_valid` and go to IDLE, or to DRAIN if the result came from ERR.
- **Core operands.** `core_dividend` and `core_divider` are driven from the op register. They are stable from ISSUE through CAPTURE.
- **Core ready.** `core_ready` is ignored outside WAIT.
- **Reset.** Reset mid-operation enters DRAIN. The core has no reset, so the block waits out any in-flight division before issuing again. The FIFO is emptied and `out_valid` is cleared.

## Timing
- **Core latency.** The core samples `core_start` at edge E. It finishes at E+WIDTH, and `core_ready` is high in the following cycle. The FSM samples it at E+WIDTH+1; CAPTURE latches at E+WIDTH+2.
- **Normal latency.** With an empty FIFO, the FSM in IDLE and output free: input handshake at edge 0 → `out_valid` is visible after edge WIDTH+4. For WIDTH=8 this is 12 cycles.
- **Divide-by-zero latency.** Input handshake at edge 0 → `out_valid` after edge 2.
- **Throughput.** Back-to-back results with `out_ready`=1 are spaced WIDTH+5 cycles apart, because HOLD costs one cycle.
- **Drain.** The first `in_ready`=1 occurs `WIDTH+3` cycles after reset release.

## Structure
- **Package `div_pkg`:** FSM state enum (DRAIN, IDLE, ISSUE, WAIT, CAPTURE, DZ, ERR, HOLD), a function returning `WIDTH+3` for drain length, and a function returning `WIDTH+1+SLACK` for timeout.
- **Sub-module `div_op_fifo`:** parameterised `{tag, divisor, dividend}` FIFO with count, push and pop. The FSM, timeout/drain counter and output register stay in the top module.

## Test plan
- **Basic divide:** WIDTH=8, reset, wait for DRAIN, push 100/7 tag 3 → `out_valid` 12 cycles later with q=14, r=2, tag=3, dz=0.
- **Divide by zero:** push 55/0 → `out_valid` after 2 cycles with q=0xFF, r=55, dz=1; `core_start` never pulses.
- **Full FIFO and backpressure:** push 5 requests while `out_ready`=0 → `in_ready` drops after the FIFO fills. The first result is held stable for 20 cycles. Releasing `out_ready` drains all results in tag order.
- **Timeout:** a core stub never asserts `core_ready` → `out_err`=1 with q=r=0 at `WIDTH+1+SLACK` cycles after the WAIT entry, then DRAIN, then the next request processes normally.
- **Reset mid-division:** assert `rst_n`=0 during WAIT → all outputs return to reset values. `in_ready` stays 0 for 11 cycles after release.
- **Simultaneous push and pop:** push during the pop cycle with count=1 → count stays 1 and there is no loss or duplication.
